mem_seq: RTL and testbench

//  Memory access sequencer directly downstream of the MMU. Takes the core's load/store/fetch

---
 rtl/mem_seq.sv | 163 ++++++++++++++++
 tb/tb_mem_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// mem_seq: memory access sequencer sitting behind the MMU.
// Turns a core load/store/fetch into one (byte) or two (word, little-endian)
// beats on an 8-bit external bus, or reports an MMU / misalignment fault.
// A bus timeout ends the access with a bus-error status. Completion is a
// one-cycle done pulse with fault status and read data.
module mem_seq #(
  parameter int RV      = 16,
  parameter int PA      = RV,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          is_pc,
  input  logic          is_write,
  input  logic          is_byte,
  input  logic          a0,
  input  logic [PA-2:0] addrp,
  input  logic [RV-1:0] wdata,
  input  logic          mmu_enable,
  input  logic          mmu_miss_fault,
  input  logic          mmu_prot_fault,
  output logic          mmu_fault,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fault,
  output logic [RV-1:0] rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [PA-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t          state_r;
  logic [PA-1:0]   addr_r;
  logic [RV-1:0]   wdata_r;
  logic            byte_r;
  logic            wr_r;
  logic [7:0]      rbuf_r;
  logic [CW-1:0]   cnt_r;
  logic            beat_tmo_s;

  // MMU fault is only meaningful while a new request is being accepted
  assign mmu_fault = (state_r == IDLE) & req & mmu_enable &
                     (mmu_miss_fault | (is_write & ~is_pc & mmu_prot_fault));

  assign busy = (state_r != IDLE);

  // the beat in flight has waited its last allowed cycle without an ack
  assign beat_tmo_s = (cnt_r == CW'(TIMEOUT - 1));

  // sequencer: request acceptance, beat issue, ack/timeout handling, done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      wdata_r   <= '0;
      byte_r    <= 1'b0;
      wr_r      <= 1'b0;
      rbuf_r    <= 8'h00;
      cnt_r     <= '0;
      done      <= 1'b0;
      fault     <= 2'd0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req && mmu_fault) begin
            fault   <= 2'd1;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (req && !is_byte && a0) begin
            fault   <= 2'd2;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (req) begin
            addr_r    <= {addrp, a0};
            wdata_r   <= wdata;
            byte_r    <= is_byte;
            wr_r      <= is_write & ~is_pc;
            mem_req   <= 1'b1;
            mem_wr    <= is_write & ~is_pc;
            mem_addr  <= is_byte ? {addrp, a0} : {addrp, 1'b0};
            // byte lane follows a0; word accesses always start with the low byte
            mem_wdata <= (is_byte && a0) ? wdata[15:8] : wdata[7:0];
            cnt_r     <= '0;
            state_r   <= BEAT0;
          end else begin
            state_r <= IDLE;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            cnt_r   <= '0;
            if (byte_r) begin
              if (!wr_r) begin
                rdata <= {8'h00, mem_rdata};
              end
              fault   <= 2'd0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              rbuf_r    <= mem_rdata;
              mem_addr  <= {addr_r[PA-1:1], 1'b1};
              mem_wdata <= wdata_r[15:8];
              state_r   <= BEAT1;
            end
          end else if (beat_tmo_s) begin
            mem_req <= 1'b0;
            fault   <= 2'd3;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        BEAT1: begin
          // first BEAT1 cycle is the mandatory request gap between beats
          if (!mem_req) begin
            mem_req <= 1'b1;
            cnt_r   <= '0;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            cnt_r   <= '0;
            if (!wr_r) begin
              rdata <= {mem_rdata, rbuf_r};
            end
            fault   <= 2'd0;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (beat_tmo_s) begin
            mem_req <= 1'b0;
            fault   <= 2'd3;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: directed self-checking bench for mem_seq (TIMEOUT = 4).
// A small bus responder acks beats in the same cycle they are requested
// (all beats, even addresses only, or never) and returns fixed read bytes.
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, is_pc, is_write, is_byte, a0;
  logic [14:0] addrp;
  logic [15:0] wdata;
  logic        mmu_enable, mmu_miss_fault, mmu_prot_fault;
  logic        mmu_fault, busy, done;
  logic [1:0]  fault;
  logic [15:0] rdata;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  int          ack_mode = 1;   // 0 never, 1 always, 2 even addresses only
  int          beat_total = 0;
  int          req_cycles = 0;
  int          done_total = 0;
  logic [15:0] log_addr [0:63];
  logic        log_wr   [0:63];
  logic [7:0]  log_wd   [0:63];

  mem_seq #(.RV(16), .PA(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .is_pc(is_pc), .is_write(is_write),
    .is_byte(is_byte), .a0(a0), .addrp(addrp), .wdata(wdata),
    .mmu_enable(mmu_enable), .mmu_miss_fault(mmu_miss_fault),
    .mmu_prot_fault(mmu_prot_fault), .mmu_fault(mmu_fault), .busy(busy),
    .done(done), .fault(fault), .rdata(rdata), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] addr);
    case (addr)
      16'h0200: mem_byte = 8'h34;
      16'h0201: mem_byte = 8'h12;
      default:  mem_byte = 8'h5A;
    endcase
  endfunction

  // bus responder: ack in the same cycle the beat is requested
  always @(negedge clk) begin
    mem_ack   = mem_req && ((ack_mode == 1) || ((ack_mode == 2) && !mem_addr[0]));
    mem_rdata = mem_byte(mem_addr);
  end

  // log completed beats, requested cycles and done pulses
  always @(posedge clk) begin
    if (mem_req) req_cycles++;
    if (done) done_total++;
    if (mem_req && mem_ack) begin
      if (beat_total < 64) begin
        log_addr[beat_total] = mem_addr;
        log_wr[beat_total]   = mem_wr;
        log_wd[beat_total]   = mem_wdata;
      end
      beat_total++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // issue one request, hold it until done (bounded), check latency and status
  task automatic run_req(input string tag, input logic pc, input logic wr, input logic byt,
                         input logic lo, input logic [14:0] ap, input logic [15:0] wd,
                         input logic en, input logic miss, input logic prot,
                         input int exp_lat, input logic [1:0] exp_fault,
                         input logic exp_mf, output int first_beat);
    int lat;
    @(posedge clk); #1;
    is_pc = pc; is_write = wr; is_byte = byt; a0 = lo; addrp = ap; wdata = wd;
    mmu_enable = en; mmu_miss_fault = miss; mmu_prot_fault = prot; req = 1'b1;
    first_beat = beat_total;
    #1;
    check({tag, " mmu_fault"}, 32'(mmu_fault), 32'(exp_mf));
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " fault"}, 32'(fault), 32'(exp_fault));
    req = 1'b0; mmu_miss_fault = 1'b0; mmu_prot_fault = 1'b0;
    @(posedge clk); #1;
    check({tag, " done width"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int b;
    int rc;
    int dc;
    reset = 1'b1; req = 1'b0; is_pc = 1'b0; is_write = 1'b0; is_byte = 1'b0;
    a0 = 1'b0; addrp = 15'h0; wdata = 16'h0; mmu_enable = 1'b0;
    mmu_miss_fault = 1'b0; mmu_prot_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset rdata", 32'(rdata), 32'h0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_wr", 32'(mem_wr), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    check("reset mem_wdata", 32'(mem_wdata), 32'h0);
    reset = 1'b0;

    // word read 0x0200: beats 0x0200/0x0201 with one idle request cycle between them
    run_req("wrd rd", 1'b0, 1'b0, 1'b0, 1'b0, 15'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 4, 2'd0, 1'b0, b);
    check("wrd rd beats", 32'(beat_total - b), 32'd2);
    check("wrd rd b0 addr", 32'(log_addr[b]), 32'h0200);
    check("wrd rd b1 addr", 32'(log_addr[b+1]), 32'h0201);
    check("wrd rd b0 wr", 32'(log_wr[b]), 32'd0);
    check("wrd rd rdata", 32'(rdata), 32'h1234);

    // byte store 0xAB00 to odd byte of 0x0300: high lane on 0x0301
    run_req("byt st", 1'b0, 1'b1, 1'b1, 1'b1, 15'h0180, 16'hAB00, 1'b0, 1'b0, 1'b0, 2, 2'd0, 1'b0, b);
    check("byt st beats", 32'(beat_total - b), 32'd1);
    check("byt st addr", 32'(log_addr[b]), 32'h0301);
    check("byt st wr", 32'(log_wr[b]), 32'd1);
    check("byt st wdata", 32'(log_wd[b]), 32'hAB);
    check("byt st rdata kept", 32'(rdata), 32'h1234);

    // byte read at 0x0201 is zero-extended
    run_req("byt rd", 1'b0, 1'b0, 1'b1, 1'b1, 15'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 2, 2'd0, 1'b0, b);
    check("byt rd addr", 32'(log_addr[b]), 32'h0201);
    check("byt rd rdata", 32'(rdata), 32'h0012);

    // MMU miss: fault reported the cycle after req, no bus traffic
    run_req("miss", 1'b0, 1'b0, 1'b0, 1'b0, 15'h0100, 16'h0, 1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b1, b);
    check("miss beats", 32'(beat_total - b), 32'd0);
    check("miss rdata kept", 32'(rdata), 32'h0012);

    // misaligned word store, then the same with a protection fault (MMU wins)
    run_req("misal", 1'b0, 1'b1, 1'b0, 1'b1, 15'h0100, 16'h1111, 1'b1, 1'b0, 1'b0, 1, 2'd2, 1'b0, b);
    check("misal beats", 32'(beat_total - b), 32'd0);
    run_req("misal prot", 1'b0, 1'b1, 1'b0, 1'b1, 15'h0100, 16'h1111, 1'b1, 1'b0, 1'b1, 1, 2'd1, 1'b1, b);
    check("misal prot beats", 32'(beat_total - b), 32'd0);

    // word store 0xBEEF to 0x0400: low byte first
    run_req("wrd st", 1'b0, 1'b1, 1'b0, 1'b0, 15'h0200, 16'hBEEF, 1'b0, 1'b0, 1'b0, 4, 2'd0, 1'b0, b);
    check("wrd st b0 addr", 32'(log_addr[b]), 32'h0400);
    check("wrd st b0 wdata", 32'(log_wd[b]), 32'hEF);
    check("wrd st b1 addr", 32'(log_addr[b+1]), 32'h0401);
    check("wrd st b1 wdata", 32'(log_wd[b+1]), 32'hBE);
    check("wrd st b1 wr", 32'(log_wr[b+1]), 32'd1);

    // fetch forces a read: protection fault ignored even with is_write set
    run_req("fetch", 1'b1, 1'b1, 1'b1, 1'b0, 15'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 2, 2'd0, 1'b0, b);
    check("fetch wr", 32'(log_wr[b]), 32'd0);
    check("fetch rdata", 32'(rdata), 32'h0034);

    // translation off: miss flag ignored
    run_req("mmu off", 1'b0, 1'b0, 1'b0, 1'b0, 15'h0100, 16'h0, 1'b0, 1'b1, 1'b0, 4, 2'd0, 1'b0, b);
    check("mmu off rdata", 32'(rdata), 32'h1234);

    // no ack: request held 4 cycles, then bus error with rdata untouched
    ack_mode = 0;
    rc = req_cycles;
    run_req("tmo", 1'b0, 1'b0, 1'b0, 1'b0, 15'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 5, 2'd3, 1'b0, b);
    check("tmo req cycles", 32'(req_cycles - rc), 32'd4);
    check("tmo beats", 32'(beat_total - b), 32'd0);
    check("tmo rdata kept", 32'(rdata), 32'h1234);

    // reset while the second beat is waiting for its ack
    ack_mode = 2;
    @(posedge clk); #1;
    is_pc = 1'b0; is_write = 1'b0; is_byte = 1'b0; a0 = 1'b0; addrp = 15'h0100;
    mmu_enable = 1'b0; req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst beat1 mem_req", 32'(mem_req), 32'd1);
    check("rst beat1 addr", 32'(mem_addr), 32'h0201);
    dc = done_total;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rdata", 32'(rdata), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("rst no done", 32'(done_total - dc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
